// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator unit: default parameters and FSM state encoding.
package acc_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 10;
  localparam int NSAMP_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/acc_unit_if.sv
// Bus between the sample source (master) and the accumulator unit (slave).
interface acc_unit_if
  import acc_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int NSAMP = NSAMP_DEF
);
  localparam int CW = $clog2(NSAMP + 1);

  logic          en;
  logic [DW-1:0] din;
  logic          start;
  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic          ovf;
  logic          done;

  modport master (output en, din, start, input acc, count, ovf, done);
  modport slave  (input en, din, start, output acc, count, ovf, done);
endinterface

// File: rtl/rise_det.sv
// Rising-edge detector: registers d and flags the cycle where d goes 0 -> 1.
module rise_det (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  // previous-cycle copy of d
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/acc_unit.sv
// Saturating sample accumulator: counts NSAMP enable edges per run, adds din on each,
// and pulses done once the run completes.
module acc_unit
  import acc_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int NSAMP = NSAMP_DEF
) (
  input  logic       clk,
  input  logic       clr_n,
  acc_unit_if.slave  bus
);
  localparam int            CW       = $clog2(NSAMP + 1);
  localparam logic [AW-1:0] ACC_MAX  = {AW{1'b1}};
  localparam logic [CW-1:0] LAST_CNT = CW'(NSAMP - 1);

  state_e        state_r, state_nxt_s;
  logic [AW-1:0] acc_r, acc_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          ovf_r, ovf_nxt_s;
  logic          done_r;
  logic          en_rise_s;
  logic [AW:0]   sum_s;

  rise_det u_rise_det (
    .clk   (clk),
    .clr_n (clr_n),
    .d     (bus.en),
    .rise  (en_rise_s)
  );

  // one spare bit catches the carry that signals saturation
  assign sum_s = {1'b0, acc_r} + {{(AW + 1 - DW){1'b0}}, bus.din};

  // next-state and datapath decode; start overrides everything else
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    if (bus.start) begin
      state_nxt_s = ST_ACCUM;
      acc_nxt_s   = {AW{1'b0}};
      count_nxt_s = {CW{1'b0}};
      ovf_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_ACCUM: begin
          if (en_rise_s) begin
            acc_nxt_s   = sum_s[AW] ? ACC_MAX : sum_s[AW-1:0];
            ovf_nxt_s   = ovf_r | sum_s[AW];
            count_nxt_s = count_r + CW'(1);
            if (count_r == LAST_CNT) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_ACCUM;
            end
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // state and datapath registers; done tracks the DONE state cycle-for-cycle
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
      acc_r   <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.acc   = acc_r;
  assign bus.count = count_r;
  assign bus.ovf   = ovf_r;
  assign bus.done  = done_r;
endmodule

// File: tb/tb_acc_unit.sv
// Directed + randomized bench for acc_unit against a run-level behavioural model.
module tb_acc_unit;
  localparam int DW      = 8;
  localparam int AW      = 10;
  localparam int NSAMP   = 8;
  localparam int ACC_MAX = (1 << AW) - 1;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  acc_unit_if #(.DW(DW), .AW(AW), .NSAMP(NSAMP)) bus ();

  acc_unit #(.DW(DW), .AW(AW), .NSAMP(NSAMP)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // model: a run is active after start until NSAMP edges have been counted
  int m_acc, m_cnt;
  bit m_ovf, m_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit exp_done);
    chk({tag, ".acc"},   32'(bus.acc),   m_acc);
    chk({tag, ".count"}, 32'(bus.count), m_cnt);
    chk({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
    chk({tag, ".done"},  32'(bus.done),  32'(exp_done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_run = 1'b0;
  endtask

  // returns 1 when this edge completes the run
  function automatic bit model_edge(input int d);
    if (!m_run) return 1'b0;
    m_acc = m_acc + d;
    if (m_acc > ACC_MAX) begin
      m_acc = ACC_MAX;
      m_ovf = 1'b1;
    end
    m_cnt++;
    if (m_cnt == NSAMP) begin
      m_run = 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic do_start(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_run = 1'b1;
    check_outs(tag, 1'b0);
  endtask

  // one-cycle en pulse, then one low cycle with junk on din
  task automatic pulse(input int d, input string tag);
    bit dn;
    bus.en  = 1'b1;
    bus.din = DW'(d);
    tick();
    bus.en  = 1'b0;
    bus.din = DW'($urandom);
    dn = model_edge(d);
    check_outs(tag, dn);
    tick();
    check_outs({tag, ".after"}, 1'b0);
  endtask

  initial begin
    bus.en = 1'b0; bus.din = '0; bus.start = 1'b0;
    clr_n = 1'b0;
    model_reset();
    tick(); tick();
    check_outs("reset", 1'b0);
    clr_n = 1'b1;
    tick();

    // pulses in IDLE without start are ignored
    for (int i = 0; i < 3; i++) pulse(50, $sformatf("idle%0d", i));

    // eight clean pulses of 10
    do_start("s10");
    for (int i = 0; i < NSAMP; i++) pulse(10, $sformatf("p10_%0d", i));
    pulse(10, "p10_post_done");

    // saturation run with 200s
    do_start("s200");
    for (int i = 0; i < NSAMP; i++) pulse(200, $sformatf("p200_%0d", i));

    // level held high counts once
    do_start("shold");
    bus.en = 1'b1; bus.din = DW'(7);
    tick();
    void'(model_edge(7));
    check_outs("hold0", 1'b0);
    for (int i = 1; i < 5; i++) begin
      bus.din = DW'($urandom);
      tick();
      check_outs($sformatf("hold%0d", i), 1'b0);
    end
    bus.en = 1'b0;
    tick();
    check_outs("hold_low", 1'b0);

    // asynchronous reset mid-run
    do_start("srst");
    for (int i = 0; i < 3; i++) pulse(5, $sformatf("p5_%0d", i));
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst", 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    pulse(40, "post_rst_ignored");

    // start wins over a simultaneous en edge
    do_start("sprio");
    for (int i = 0; i < 4; i++) pulse(int'($urandom_range(0, 255)), $sformatf("pprio_%0d", i));
    bus.start = 1'b1; bus.en = 1'b1; bus.din = DW'(99);
    tick();
    bus.start = 1'b0; bus.en = 1'b0;
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_run = 1'b1;
    check_outs("prio", 1'b0);
    tick();
    pulse(3, "prio_next");

    // en already high across reset release produces no edge
    bus.en = 1'b1;
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    model_reset();
    tick(); tick();
    do_start("s_enhigh");
    tick();
    check_outs("enhigh_held", 1'b0);
    bus.en = 1'b0;
    tick();
    pulse(9, "enhigh_fresh");

    // randomized full runs
    for (int r = 0; r < 4; r++) begin
      do_start($sformatf("srand%0d", r));
      for (int i = 0; i < NSAMP; i++)
        pulse(int'($urandom_range(0, 255)), $sformatf("rand%0d_%0d", r, i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 SHALL have parameter DW, default 8, data input width.
REQ-002 SHALL have parameter AW, default 10, accumulator width (AW > DW).
REQ-003 SHALL have parameter NSAMP, default 8, number of accumulations per run (NSAMP >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port clr_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  level enable from the upstream sequence-detector FSM output, synchronous to clk.
REQ-007 SHALL have port din  input  DW  unsigned sample, added on each qualified enable.
REQ-008 SHALL have port start  input  1  synchronous pulse; clears and begins a run.
REQ-009 SHALL have port acc  output  AW  running accumulator value.
REQ-010 SHALL have port count  output  $clog2(NSAMP+1)  accumulations done in the current run.
REQ-011 SHALL have port ovf  output  1  sticky saturation flag for the current run.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking run completion.

Function
REQ-013 SHALL register en into en_q each cycle; en_rise = en & ~en_q is the only accumulate qualifier, so a level held high for any number of cycles counts once.
REQ-014 SHALL implement states IDLE, ACCUM and DONE.
REQ-015 IDLE: acc, count and ovf SHALL hold; en_rise SHALL be ignored.
REQ-016 start in any state SHALL, at the next edge, clear acc, count and ovf to 0 and enter ACCUM; start SHALL take priority over en_rise in the same cycle.
REQ-017 ACCUM with en_rise SHALL, at that edge, set acc <= acc + zero-extended din and count <= count + 1, visible one cycle after the sampling edge.
REQ-018 Sum arithmetic SHALL use AW+1 bits; if the sum exceeds 2^AW-1, acc SHALL saturate to 2^AW-1 and ovf SHALL set, remaining 1 until the next start or reset.
REQ-019 Once saturated, further additions SHALL keep acc at 2^AW-1 while count still increments.
REQ-020 When en_rise occurs with count == NSAMP-1, the state SHALL move to DONE on the same edge that makes count == NSAMP.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; acc, count and ovf SHALL hold the final values.
REQ-022 done SHALL be a registered decode of state == DONE and SHALL be 0 in every other state.
REQ-023 din SHALL be sampled only on en_rise cycles; other values SHALL have no effect.

Reset
REQ-024 clr_n low SHALL, asynchronously and at any time including mid-run, force state = IDLE, acc = 0, count = 0, ovf = 0, done = 0, en_q = 0.
REQ-025 After clr_n deasserts, en already high SHALL NOT produce en_rise until it falls and rises again, because en_q stays 0 only in IDLE, which ignores en_rise.

Structure
REQ-026 State encodings (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10) and default parameter values SHALL live in a shared package, acc_pkg.
REQ-027 Edge detection SHALL be a separate sub-module, rise_det (clk, clr_n, d, rise), instantiated once.
REQ-028 The rest (FSM, datapath, saturation) SHALL reside in acc_unit.

Verification
REQ-029 start, then 8 separate one-cycle en pulses with din=10 -> acc=80, count=8, ovf=0, done high exactly one cycle after the 8th update, then IDLE.
REQ-030 start, en held high 5 cycles with din=7, then low -> acc=7, count=1 (single edge counted).
REQ-031 start, 8 en pulses with din=200 -> acc 200,400,600,800,1000, then 1023 with ovf=1 at the 6th; acc=1023 and count=8 at done.
REQ-032 clr_n pulsed low mid-ACCUM after 3 pulses with din=5 -> acc, count, ovf and done read 0 immediately (before the next clk edge); state IDLE; later en pulses are ignored until start.
REQ-033 start asserted in the same cycle as en_rise after 4 accumulations -> acc=0, count=0, state ACCUM, that en_rise discarded.
REQ-034 en pulses in IDLE (no start) with din=50 -> acc, count and done remain 0.
